// File: rtl/scm_pkg.sv
// Shared types and default widths for the SCM stream reader.
package scm_pkg;

  localparam int unsigned SCM_ADDR_WIDTH = 5;
  localparam int unsigned SCM_DATA_WIDTH = 32;
  localparam int unsigned SCM_BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } scm_state_e;

  typedef logic [SCM_ADDR_WIDTH-1:0] scm_addr_t;
  typedef logic [SCM_ADDR_WIDTH:0]   scm_len_t;

endpackage

// File: rtl/scm_stream_reader_if.sv
// Control, SCM read port and output stream of the SCM stream reader.
interface scm_stream_reader_if
  import scm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SCM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SCM_DATA_WIDTH
);

  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   len_i;
  logic                  abort_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  last_o;

  // Reader side.
  modport master (
    input  start_i, base_addr_i, len_i, abort_i, rd_data_i, ready_i,
    output busy_o, done_o, err_o, rd_en_o, rd_addr_o, data_o, valid_o, last_o
  );

  // Controller / SCM / consumer side.
  modport slave (
    output start_i, base_addr_i, len_i, abort_i, rd_data_i, ready_i,
    input  busy_o, done_o, err_o, rd_en_o, rd_addr_o, data_o, valid_o, last_o
  );

endinterface

// File: rtl/scm_reader_buf.sv
// Small FIFO of read words with a last flag; clr empties it synchronously.
module scm_reader_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            push_data,
  input  logic                             push_last,
  input  logic                             pop,
  output logic [DATA_WIDTH-1:0]            head_data,
  output logic                             head_last,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  mem_last;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push on full is only legal together with a pop; pop on empty is dropped.
  always_comb begin
    do_pop  = pop & (count_q != '0);
    do_push = push & ((count_q != CNT_W'(BUF_DEPTH)) | do_pop);
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Word storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr_q] <= push_data;
      mem_last[wr_ptr_q] <= push_last;
    end
  end

  assign head_data = mem_data[rd_ptr_q];
  assign head_last = mem_last[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/scm_stream_reader.sv
// Drains a contiguous SCM word range into a valid/ready stream.
// Build option SCM_READER_WRAP_EN: ranges past the top wrap to address 0
// instead of being rejected with err_o.
module scm_stream_reader
  import scm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SCM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SCM_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = SCM_BUF_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  scm_stream_reader_if.master bus
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
`ifndef SCM_READER_WRAP_EN
  localparam int unsigned NUM_WORDS = 1 << ADDR_WIDTH;
`endif

  scm_state_e            state_q;
  scm_state_e            state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      rem_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  done_q;
  logic                  err_q;

  logic [CNT_W-1:0]      buf_count;
  logic [DATA_WIDTH-1:0] buf_head_data;
  logic                  buf_head_last;

  logic                  buf_nonempty_c;
  logic                  out_valid_c;
  logic                  out_last_c;
  logic [DATA_WIDTH-1:0] out_data_c;
  logic                  pop_c;
  logic [OCC_W-1:0]      occ_c;
  logic                  kill_c;
  logic                  final_pop_c;
  logic                  last_issue_c;
  logic                  overrun_c;
  logic                  accept_c;
  logic                  issue_c;
  logic                  done_d;
  logic                  err_d;

  // Stream head: oldest buffered word, else the read returning this cycle.
  always_comb begin
    buf_nonempty_c = (buf_count != '0);
    out_valid_c    = buf_nonempty_c | inflight_q;
    out_data_c     = '0;
    out_last_c     = 1'b0;
    if (buf_nonempty_c) begin
      out_data_c = buf_head_data;
      out_last_c = buf_head_last;
    end else if (inflight_q) begin
      out_data_c = bus.rd_data_i;
      out_last_c = inflight_last_q;
    end
    pop_c        = out_valid_c & bus.ready_i;
    occ_c        = OCC_W'(buf_count) + OCC_W'(inflight_q) - OCC_W'(pop_c);
    kill_c       = bus.abort_i & (state_q != ST_IDLE);
    final_pop_c  = pop_c & out_last_c;
    last_issue_c = (rem_q == LEN_W'(1));
  end

`ifdef SCM_READER_WRAP_EN
  assign overrun_c = 1'b0;
`else
  assign overrun_c = (LEN_W'(bus.base_addr_i) + bus.len_i) > LEN_W'(NUM_WORDS);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (kill_c)                        state_d = ST_IDLE;
        else if (issue_c && last_issue_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (kill_c || final_pop_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state decisions: start accept/reject, read issue, completion.
  always_comb begin
    accept_c = 1'b0;
    issue_c  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (overrun_c)              err_d    = 1'b1;
          else if (bus.len_i == '0)   done_d   = 1'b1;
          else                        accept_c = 1'b1;
        end
      end
      ST_ISSUE: begin
        issue_c = !kill_c && (occ_c < OCC_W'(BUF_DEPTH));
        done_d  = kill_c;
      end
      ST_DRAIN: done_d = kill_c | final_pop_c;
      default: ;
    endcase
  end

  // Address/remaining counters, single outstanding read, status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (accept_c) begin
        addr_q <= bus.base_addr_i;
        rem_q  <= bus.len_i;
      end else if (issue_c) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - LEN_W'(1);
      end
      if (kill_c) begin
        inflight_q      <= 1'b0;
        inflight_last_q <= 1'b0;
      end else begin
        inflight_q      <= issue_c;
        inflight_last_q <= issue_c & last_issue_c;
      end
    end
  end

  // A returning word bypasses the buffer only when it is consumed at once.
  scm_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .clr       (rst | kill_c),
    .push      (inflight_q & ~(pop_c & ~buf_nonempty_c)),
    .push_data (bus.rd_data_i),
    .push_last (inflight_last_q),
    .pop       (pop_c & buf_nonempty_c),
    .head_data (buf_head_data),
    .head_last (buf_head_last),
    .count     (buf_count)
  );

  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;
  assign bus.rd_en_o   = issue_c;
  assign bus.rd_addr_o = addr_q;
  assign bus.data_o    = out_data_c;
  assign bus.valid_o   = out_valid_c;
  assign bus.last_o    = out_last_c;

endmodule

// File: tb/tb_scm_stream_reader.sv
// Self-checking bench for scm_stream_reader with an SCM model and stream scoreboard.
module tb_scm_stream_reader;
  import scm_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = 32;
  localparam int          NW = 32;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scm_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  scm_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SCM read port model: data appears the cycle after the enable.
  logic [DW-1:0] mem [NW];
  logic [DW-1:0] rd_data_q = '0;
  always @(posedge clk) if (bus.rd_en_o) rd_data_q <= mem[bus.rd_addr_o];
  assign bus.rd_data_i = rd_data_q;

  int n_tests = 0;
  int n_fail  = 0;

  scm_addr_t     iss_q[$];
  logic [DW:0]   rx_q[$];
  int n_done = 0, n_err = 0, n_valid = 0, occ_viol = 0, stab_viol = 0, outst = 0;

  // Observer: records issues, handshakes, pulses, occupancy and stall stability.
  initial begin : monitor
    logic        prev_stall;
    logic [DW:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outst      = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!bus.valid_o || {bus.last_o, bus.data_o} !== prev_word)) stab_viol++;
        if (bus.rd_en_o) begin
          iss_q.push_back(bus.rd_addr_o);
          outst++;
        end
        if (bus.valid_o) n_valid++;
        if (bus.valid_o && bus.ready_i) begin
          rx_q.push_back({bus.last_o, bus.data_o});
          outst--;
        end
        if (outst > DEPTH) occ_viol++;
        if (bus.done_o) n_done++;
        if (bus.err_o)  n_err++;
        prev_stall = bus.valid_o && !bus.ready_i && !(bus.abort_i && bus.busy_o);
        prev_word  = {bus.last_o, bus.data_o};
        if (bus.abort_i && bus.busy_o) outst = 0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic rdy(input int mode, input int k, input int hold);
    case (mode)
      0:       return 1'b1;
      1:       return k[0];
      2:       return 1'($urandom_range(0, 1));
      default: return (k >= hold);
    endcase
  endfunction

  // One transfer, checked word by word against mem[(base+i) mod NW].
  task automatic run_xfer(input string tag, input int base, input int len,
                          input int mode, input int hold, output int iss_at_hold);
    int iss0, rx0, d0, stab0, occ0, k;
    iss0 = iss_q.size();
    rx0  = rx_q.size();
    d0   = n_done;
    stab0 = stab_viol;
    occ0  = occ_viol;
    iss_at_hold = -1;
    bus.start_i     = 1'b1;
    bus.base_addr_i = AW'(base);
    bus.len_i       = LW'(len);
    bus.ready_i     = rdy(mode, 0, hold);
    cyc();
    bus.start_i = 1'b0;
    k = 1;
    while (n_done == d0 && k < 3000) begin
      if (k == hold) iss_at_hold = iss_q.size() - iss0;
      bus.ready_i = rdy(mode, k, hold);
      cyc();
      k++;
    end
    bus.ready_i = 1'b0;
    cyc(2);
    #1;
    chk($sformatf("%s done_count", tag), 64'(n_done - d0), 64'd1);
    chk($sformatf("%s busy_after", tag), 64'(bus.busy_o), 64'd0);
    chk($sformatf("%s issue_count", tag), 64'(iss_q.size() - iss0), 64'(len));
    chk($sformatf("%s word_count", tag), 64'(rx_q.size() - rx0), 64'(len));
    for (int i = 0; i < len; i++) begin
      if (iss0 + i < iss_q.size())
        chk($sformatf("%s addr%0d", tag, i), 64'(iss_q[iss0 + i]), 64'((base + i) % NW));
      if (rx0 + i < rx_q.size())
        chk($sformatf("%s word%0d", tag, i), 64'(rx_q[rx0 + i]),
            64'({(i == len - 1), mem[(base + i) % NW]}));
    end
    chk($sformatf("%s stall_stable", tag), 64'(stab_viol - stab0), 64'd0);
    chk($sformatf("%s occupancy", tag), 64'(occ_viol - occ0), 64'd0);
  endtask

  initial begin : stim
    int d0, e0, iss0, rx0, v0, k, hold_iss, base, len;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.len_i       = '0;
    bus.abort_i     = 1'b0;
    bus.ready_i     = 1'b0;
    cyc(3);
    #1;
    chk("reset busy",    64'(bus.busy_o),    64'd0);
    chk("reset valid",   64'(bus.valid_o),   64'd0);
    chk("reset rd_en",   64'(bus.rd_en_o),   64'd0);
    chk("reset rd_addr", 64'(bus.rd_addr_o), 64'd0);
    chk("reset done",    64'(bus.done_o),    64'd0);
    chk("reset err",     64'(bus.err_o),     64'd0);
    chk("reset last",    64'(bus.last_o),    64'd0);
    chk("reset data",    64'(bus.data_o),    64'd0);
    rst = 1'b0;
    cyc();

    // base=4 len=3, ready high: cycle-exact latency and throughput.
    d0 = n_done;
    bus.start_i = 1'b1; bus.base_addr_i = AW'(4); bus.len_i = LW'(3); bus.ready_i = 1'b1;
    #1;
    chk("t1 c0 rd_en", 64'(bus.rd_en_o), 64'd0);
    cyc();
    bus.start_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("t1 c%0d busy", c),  64'(bus.busy_o),  64'd1);
      chk($sformatf("t1 c%0d rd_en", c), 64'(bus.rd_en_o), 64'(c <= 3));
      if (c <= 3) chk($sformatf("t1 c%0d rd_addr", c), 64'(bus.rd_addr_o), 64'(3 + c));
      chk($sformatf("t1 c%0d valid", c), 64'(bus.valid_o), 64'(c >= 2));
      if (c >= 2) begin
        chk($sformatf("t1 c%0d data", c), 64'(bus.data_o), 64'(mem[2 + c]));
        chk($sformatf("t1 c%0d last", c), 64'(bus.last_o), 64'(c == 4));
      end
      chk($sformatf("t1 c%0d done", c), 64'(bus.done_o), 64'd0);
      cyc();
    end
    #1;
    chk("t1 c5 done",  64'(bus.done_o),  64'd1);
    chk("t1 c5 busy",  64'(bus.busy_o),  64'd0);
    chk("t1 c5 valid", 64'(bus.valid_o), 64'd0);
    cyc();
    #1;
    chk("t1 c6 done", 64'(bus.done_o), 64'd0);
    chk("t1 done_total", 64'(n_done - d0), 64'd1);
    bus.ready_i = 1'b0;
    cyc();

    // Full range with alternating backpressure.
    run_xfer("t2 len32 toggle", 0, 32, 1, 0, hold_iss);

    // Consumer stalled for 10 cycles: exactly two reads outstanding.
    run_xfer("t3 stall", 0, 8, 3, 10, hold_iss);
    chk("t3 issued_during_stall", 64'(hold_iss), 64'd2);

    // Range crossing the top of the SCM.
`ifdef SCM_READER_WRAP_EN
    run_xfer("t4 wrap", 30, 4, 0, 0, hold_iss);
`else
    d0 = n_done; e0 = n_err; iss0 = iss_q.size();
    bus.start_i = 1'b1; bus.base_addr_i = AW'(30); bus.len_i = LW'(4); bus.ready_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    #1;
    chk("t4 err_pulse", 64'(bus.err_o),  64'd1);
    chk("t4 busy",      64'(bus.busy_o), 64'd0);
    cyc();
    #1;
    chk("t4 err_clear", 64'(bus.err_o), 64'd0);
    cyc(3);
    chk("t4 no_issue", 64'(iss_q.size() - iss0), 64'd0);
    chk("t4 no_done",  64'(n_done - d0), 64'd0);
    chk("t4 err_once", 64'(n_err - e0), 64'd1);
    bus.ready_i = 1'b0;
`endif

    // Abort after two words; a start while busy must be ignored.
    d0 = n_done; e0 = n_err; rx0 = rx_q.size();
    bus.start_i = 1'b1; bus.base_addr_i = AW'(0); bus.len_i = LW'(16); bus.ready_i = 1'b1;
    cyc();
    bus.base_addr_i = AW'(20); bus.len_i = LW'(5);
    k = 0;
    while (rx_q.size() - rx0 < 2 && k < 50) begin
      cyc();
      k++;
    end
    chk("t5 two_words_seen", 64'(rx_q.size() - rx0 >= 2), 64'd1);
    bus.abort_i = 1'b1;
    cyc();
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("t5 valid_after", 64'(bus.valid_o), 64'd0);
    chk("t5 done_pulse",  64'(bus.done_o),  64'd1);
    chk("t5 busy_after",  64'(bus.busy_o),  64'd0);
    chk("t5 rd_en_after", 64'(bus.rd_en_o), 64'd0);
    v0 = n_valid;
    cyc(3);
    chk("t5 done_once", 64'(n_done - d0), 64'd1);
    chk("t5 no_err",    64'(n_err - e0),  64'd0);
    chk("t5 quiet",     64'(n_valid - v0), 64'd0);
    for (int j = 0; j < rx_q.size() - rx0; j++)
      chk($sformatf("t5 word%0d", j), 64'(rx_q[rx0 + j]), 64'({1'b0, mem[j]}));
    run_xfer("t5 restart", 10, 1, 0, 0, hold_iss);

    // Zero-length start, then abort while idle.
    d0 = n_done; iss0 = iss_q.size(); v0 = n_valid;
    bus.start_i = 1'b1; bus.base_addr_i = AW'(7); bus.len_i = LW'(0); bus.ready_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    #1;
    chk("t6 done_pulse", 64'(bus.done_o), 64'd1);
    chk("t6 busy",       64'(bus.busy_o), 64'd0);
    bus.abort_i = 1'b1;
    cyc();
    bus.abort_i = 1'b0;
    cyc(3);
    chk("t6 no_issue", 64'(iss_q.size() - iss0), 64'd0);
    chk("t6 no_valid", 64'(n_valid - v0), 64'd0);
    chk("t6 done_once_idle_abort", 64'(n_done - d0), 64'd1);

    // Reset in the middle of a 16-word transfer.
    d0 = n_done;
    bus.start_i = 1'b1; bus.base_addr_i = AW'(0); bus.len_i = LW'(16); bus.ready_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("t7 busy",    64'(bus.busy_o),    64'd0);
    chk("t7 valid",   64'(bus.valid_o),   64'd0);
    chk("t7 rd_en",   64'(bus.rd_en_o),   64'd0);
    chk("t7 rd_addr", 64'(bus.rd_addr_o), 64'd0);
    chk("t7 done",    64'(bus.done_o),    64'd0);
    chk("t7 err",     64'(bus.err_o),     64'd0);
    chk("t7 last",    64'(bus.last_o),    64'd0);
    chk("t7 data",    64'(bus.data_o),    64'd0);
    cyc(4);
    chk("t7 no_done", 64'(n_done - d0), 64'd0);
    bus.ready_i = 1'b0;

    // Randomized ranges and backpressure.
    for (int t = 0; t < 12; t++) begin
      base = int'($urandom_range(0, NW - 1));
`ifdef SCM_READER_WRAP_EN
      len = int'($urandom_range(1, NW));
`else
      len = int'($urandom_range(1, NW - base));
`endif
      run_xfer($sformatf("rnd%0d", t), base, len, int'($urandom_range(0, 2)), 0, hold_iss);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scm_stream_reader.md
Name: scm_stream_reader

Overview:
- Read-side initiator for the latch-based SCM register file.
- Drives one SCM read port (enable + address; data returns the cycle after enable) to drain a contiguous word range into a valid/ready output stream.
- Used for context save, debug dump and DMA-out of SCM contents.
- Sits between the SCM read port and a streaming consumer; tolerates arbitrary backpressure with no word loss.

Parameters:
- ADDR_WIDTH, 5, SCM address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, SCM word width.
- BUF_DEPTH, 2, output buffer entries (min 2 for full throughput).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  launch request; accepted only in IDLE
- base_addr_i  in  ADDR_WIDTH  first word address
- len_i  in  ADDR_WIDTH+1  number of words (0..NUM_WORDS)
- abort_i  in  1  terminate the current transfer
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse when the transfer completes or aborts
- err_o  out  1  one-cycle pulse when a start is rejected
- rd_en_o  out  1  SCM ReadEnable
- rd_addr_o  out  ADDR_WIDTH  SCM ReadAddr
- rd_data_i  in  DATA_WIDTH  SCM ReadData, valid the cycle after rd_en_o
- data_o  out  DATA_WIDTH  stream data
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- last_o  out  1  marks the final word of the transfer

Behaviour:
- Reset: FSM=IDLE, buffer empty, inflight=0. All outputs 0, including busy_o, valid_o, rd_en_o, rd_addr_o, done_o and err_o.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on an accepted start with len_i>0.
  - start with len_i==0: done_o pulses next cycle; FSM stays IDLE.
  - ISSUE -> DRAIN when the last read is issued.
  - DRAIN -> IDLE when the buffer is empty, inflight=0, and the last word has been handshaken; done_o pulses in that transition cycle.
- Start accept: registers base and len; busy_o=1 from the next cycle.
- Issue rule: rd_en_o=1 in ISSUE when (count + inflight - pop) < BUF_DEPTH.
  - pop = valid_o & ready_i.
  - rd_addr_o = current address; address increments by 1 per issue.
- Capture: in the cycle after an issue, rd_data_i is written into the buffer.
  - inflight is 1 bit (only one outstanding read).
- Throughput: ready_i held high -> one word per cycle after 2 cycles of startup latency (start -> first issue 1 cycle, issue -> valid_o 1 cycle).
- Stream order: FIFO order; data_o/last_o stay stable while valid_o & !ready_i.
- last_o: asserted with the word whose index == len-1.
- Simultaneous push and pop on a full buffer is legal; count is unchanged.
- abort_i while busy:
  - stop issuing immediately;
  - discard the buffer and any inflight word (valid_o=0 next cycle);
  - go to IDLE and pulse done_o next cycle;
  - last_o is never emitted.
- abort_i in IDLE is ignored.
- start_i while busy is ignored (no err_o).
- rst mid-transfer: returns to the reset state next cycle; no done_o.
- Address overrun (base+len > NUM_WORDS) without the optional feature: start rejected, err_o pulses, stays IDLE.
- Write coherency: a word reflects SCM contents at its capture cycle. Concurrent writes are the caller's responsibility.

Optional Feature:
- Macro SCM_READER_WRAP_EN.
- Defined: overrun is legal; the address wraps modulo NUM_WORDS (e.g. 30,31,0,1). err_o is tied 0.
- Undefined: overrun starts are rejected with an err_o pulse as specified above; no wrap logic is present.

Decomposition:
- Shared package scm_pkg:
  - state enum (IDLE/ISSUE/DRAIN);
  - scm_addr_t / scm_len_t width helpers.
- One sub-module, scm_reader_buf: parameterised BUF_DEPTH FIFO with data+last fields, push/pop, count and synchronous clear (for abort/rst).
- FSM, issue logic and address counter stay in the top module.

Test Plan:
- base=4, len=3, ready_i=1 -> rd_addr_o 4,5,6 on consecutive cycles; data words 4,5,6 on consecutive cycles; last_o on word 6; done_o once.
- base=0, len=32, ready_i toggling 1/0 -> all 32 words in order; none dropped or duplicated; rd_en_o never issues with buffer+inflight full.
- base=0, len=8, ready_i=0 for 10 cycles then 1 -> exactly 2 reads issued, then stall; data_o stable; completes after release.
- base=30, len=4 -> macro undefined: err_o=1 pulse, no rd_en_o. Macro defined: addresses 30,31,0,1.
- abort_i after 2 words, ready_i=1 -> valid_o=0 next cycle, done_o pulse, busy_o=0; new start base=10, len=1 returns word 10 with last_o.
- len=0 -> done_o one cycle later, no rd_en_o, no valid_o; rst asserted mid-transfer of len=16 -> all outputs 0 next cycle.
